// File: rtl/riscv_rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings and counter sizing.
package riscv_rst_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_REL  = 2'd2,
      ST_RUN  = 2'd3
   } rst_state_t;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/riscv_rst_sync.sv
// Reset-release synchroniser: asynchronous clear, shifts in a constant 1 on every clock.
module riscv_rst_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic sync,
   output logic sync_pre
);

   logic [STAGES-1:0] chain_reg;

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               chain_reg[gi] <= 1'b0;
            end else if (gi == 0) begin
               chain_reg[gi] <= 1'b1;
            end else begin
               chain_reg[gi] <= chain_reg[(gi == 0) ? 0 : gi-1];
            end
         end
      end
   endgenerate

   assign sync     = chain_reg[STAGES-1];
   // One stage early, so a consumer can act on the same edge the output rises.
   assign sync_pre = chain_reg[STAGES-2];

endmodule

// File: rtl/riscv_rst_seq.sv
// Reset sequencer: synchronised board-reset release, programmable hold, then staggered
// release of N_CH reset domains; a soft request replays the sequence from HOLD.
module riscv_rst_seq
   import riscv_rst_seq_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 100,
   parameter int STAGE_GAP   = 8,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sw_rst_req,
   output logic [N_CH-1:0]  rst_n_out,
   output logic             ready,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] sw_rst_cnt
);

   localparam int HOLD_W = cnt_w(HOLD_CYCLES);
   localparam int GAP_W  = cnt_w(STAGE_GAP);
   localparam int CH_W   = cnt_w(N_CH);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
   localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);

   logic rst_sync;
   logic rst_sync_pre;

   rst_state_t        state_reg;
   logic [HOLD_W-1:0] hold_cnt_reg;
   logic [GAP_W-1:0]  gap_cnt_reg;
   logic [CH_W-1:0]   ch_idx_reg;
   logic [N_CH-1:0]   rst_n_out_reg;
   logic              ready_reg;
   logic [CNT_W-1:0]  sw_rst_cnt_reg;

   riscv_rst_sync #(
      .STAGES   (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .sync     (rst_sync),
      .sync_pre (rst_sync_pre)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         hold_cnt_reg   <= '0;
         gap_cnt_reg    <= '0;
         ch_idx_reg     <= '0;
         rst_n_out_reg  <= '0;
         ready_reg      <= 1'b0;
         sw_rst_cnt_reg <= '0;
      end else begin
         case (state_reg)
            // Leaving on the look-ahead tap puts HOLD entry on the edge rst_sync rises.
            ST_IDLE: begin
               if (rst_sync_pre) begin
                  state_reg    <= ST_HOLD;
                  hold_cnt_reg <= '0;
               end
            end
            ST_HOLD: begin
               if (sw_rst_req) begin
                  hold_cnt_reg <= '0;
               end else if (rst_sync) begin
                  if (hold_cnt_reg == HOLD_LAST) begin
                     rst_n_out_reg <= N_CH'(1);
                     gap_cnt_reg   <= '0;
                     ch_idx_reg    <= CH_W'(1);
                     state_reg     <= (N_CH == 1) ? ST_RUN : ST_REL;
                  end else begin
                     hold_cnt_reg <= hold_cnt_reg + 1'b1;
                  end
               end
            end
            ST_REL, ST_RUN: begin
               if (sw_rst_req) begin
                  rst_n_out_reg <= '0;
                  ready_reg     <= 1'b0;
                  hold_cnt_reg  <= '0;
                  state_reg     <= ST_HOLD;
                  if (sw_rst_cnt_reg != '1) begin
                     sw_rst_cnt_reg <= sw_rst_cnt_reg + 1'b1;
                  end
               end else if (state_reg == ST_RUN) begin
                  ready_reg <= 1'b1;
               end else if (gap_cnt_reg == GAP_LAST) begin
                  rst_n_out_reg <= rst_n_out_reg | (N_CH'(1) << ch_idx_reg);
                  gap_cnt_reg   <= '0;
                  if (ch_idx_reg == CH_LAST) begin
                     state_reg <= ST_RUN;
                  end else begin
                     ch_idx_reg <= ch_idx_reg + 1'b1;
                  end
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign rst_n_out  = rst_n_out_reg;
   assign ready      = ready_reg;
   assign state      = state_reg;
   assign sw_rst_cnt = sw_rst_cnt_reg;

endmodule

// File: tb/tb_riscv_rst_seq.sv
// Scoreboard bench for riscv_rst_seq: default build, a saturating-counter build and a
// single-channel build share the clock and board reset.
module tb_riscv_rst_seq;
   import riscv_rst_seq_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic sw_a  = 1'b0;
   logic sw_b  = 1'b0;
   logic sw_c  = 1'b0;

   logic [3:0] rst_a;
   logic       ready_a;
   logic [1:0] state_a;
   logic [7:0] cnt_a;
   logic [1:0] rst_b;
   logic       ready_b;
   logic [1:0] state_b;
   logic [1:0] cnt_b;
   logic [0:0] rst_c;
   logic       ready_c;
   logic [1:0] state_c;
   logic [7:0] cnt_c;

   always #5 clk = ~clk;

   riscv_rst_seq u_dut_a (
      .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_a),
      .rst_n_out(rst_a), .ready(ready_a), .state(state_a), .sw_rst_cnt(cnt_a)
   );

   riscv_rst_seq #(.N_CH(2), .HOLD_CYCLES(4), .STAGE_GAP(2), .CNT_W(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_b),
      .rst_n_out(rst_b), .ready(ready_b), .state(state_b), .sw_rst_cnt(cnt_b)
   );

   riscv_rst_seq #(.N_CH(1), .HOLD_CYCLES(1), .SYNC_STAGES(2)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_c),
      .rst_n_out(rst_c), .ready(ready_c), .state(state_c), .sw_rst_cnt(cnt_c)
   );

   typedef struct {
      int    e;
      int    sel;
      int    val;
      string tag;
   } exp_t;

   exp_t sb[$];
   int cyc      = 0;
   int n_vec    = 0;
   int n_err    = 0;
   int rel_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end else begin
         $display("ok   %s: %0d (cycle %0d)", tag, got, cyc);
      end
   endtask

   function automatic int probe(input int sel);
      case (sel)
         0: return int'(rst_a);
         1: return int'(ready_a);
         2: return int'(state_a);
         3: return int'(cnt_a);
         4: return int'(rst_b);
         5: return int'(cnt_b);
         6: return int'(ready_b);
         7: return int'(rst_c);
         8: return int'(ready_c);
         9: return int'(state_c);
         default: return -1;
      endcase
   endfunction

   task automatic push(input int e, input int sel, input int val, input string tag);
      exp_t x;
      x.e = e; x.sel = sel; x.val = val; x.tag = tag;
      sb.push_back(x);
   endtask

   // Compare every entry due at this edge; an entry whose edge has passed is a miss.
   exp_t keep[$];
   always @(negedge clk) begin
      keep = {};
      foreach (sb[i]) begin
         if (sb[i].e == cyc)
            chk(sb[i].tag, probe(sb[i].sel), sb[i].val);
         else if (sb[i].e < cyc)
            chk({sb[i].tag, "_missed"}, cyc, sb[i].e);
         else
            keep.push_back(sb[i]);
      end
      sb = keep;
      if (state_c == ST_REL) rel_seen++;
   end

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic sched_boot(input int t0);
      push(t0+1,   2, ST_IDLE, "a_state_e1");
      push(t0+2,   2, ST_HOLD, "a_state_e2");
      push(t0+101, 0, 0,       "a_rst_e101");
      push(t0+102, 0, 1,       "a_rst_e102");
      push(t0+102, 2, ST_REL,  "a_state_e102");
      push(t0+109, 0, 1,       "a_rst_e109");
      push(t0+110, 0, 3,       "a_rst_e110");
      push(t0+117, 0, 3,       "a_rst_e117");
      push(t0+118, 0, 7,       "a_rst_e118");
      push(t0+125, 0, 7,       "a_rst_e125");
      push(t0+126, 0, 15,      "a_rst_e126");
      push(t0+126, 2, ST_RUN,  "a_state_e126");
      push(t0+126, 1, 0,       "a_ready_e126");
      push(t0+127, 1, 1,       "a_ready_e127");
      push(t0+5,   4, 0,       "b_rst_e5");
      push(t0+6,   4, 1,       "b_rst_e6");
      push(t0+8,   4, 3,       "b_rst_e8");
      push(t0+9,   6, 1,       "b_ready_e9");
      push(t0+2,   7, 0,       "c_rst_e2");
      push(t0+2,   9, ST_HOLD, "c_state_e2");
      push(t0+3,   7, 1,       "c_rst_e3");
      push(t0+3,   9, ST_RUN,  "c_state_e3");
      push(t0+3,   8, 0,       "c_ready_e3");
      push(t0+4,   8, 1,       "c_ready_e4");
   endtask

   task automatic chk_all_reset(input string pfx);
      chk({pfx, "_a_rst"},   int'(rst_a),   0);
      chk({pfx, "_a_ready"}, int'(ready_a), 0);
      chk({pfx, "_a_state"}, int'(state_a), ST_IDLE);
      chk({pfx, "_a_cnt"},   int'(cnt_a),   0);
      chk({pfx, "_b_rst"},   int'(rst_b),   0);
      chk({pfx, "_b_cnt"},   int'(cnt_b),   0);
      chk({pfx, "_c_rst"},   int'(rst_c),   0);
      chk({pfx, "_c_ready"}, int'(ready_c), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int k;

      #23;
      chk_all_reset("por");
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      t0 = cyc;
      sched_boot(t0);
      wait_until(t0 + 130);

      // Eight soft resets on the 2-bit counter build, each sampled in REL or RUN.
      for (int j = 0; j < 8; j++) begin
         k = cyc + 1;
         sw_b = 1'b1;
         push(k,   5, (j < 3) ? j + 1 : 3, $sformatf("b_cnt_soft%0d", j));
         push(k,   4, 0,                   $sformatf("b_rst_soft%0d", j));
         push(k+4, 4, 1,                   $sformatf("b_rel_soft%0d", j));
         @(negedge clk);
         sw_b = 1'b0;
         wait_until(k + 4);
      end

      // One-cycle soft reset while in RUN.
      k = cyc + 1;
      sw_a = 1'b1;
      push(k,     0, 0,       "a_soft_rst_k");
      push(k,     1, 0,       "a_soft_ready_k");
      push(k,     3, 1,       "a_soft_cnt_k");
      push(k,     2, ST_HOLD, "a_soft_state_k");
      push(k+99,  0, 0,       "a_soft_rst_k99");
      push(k+100, 0, 1,       "a_soft_rst_k100");
      push(k+124, 1, 0,       "a_soft_ready_k124");
      push(k+125, 1, 1,       "a_soft_ready_k125");
      @(negedge clk);
      sw_a = 1'b0;
      wait_until(k + 130);

      // Soft reset, then a restart pulse seen at hold_cnt=50.
      k = cyc + 1;
      sw_a = 1'b1;
      push(k, 3, 2, "a_hold_cnt_k");
      @(negedge clk);
      sw_a = 1'b0;
      wait_until(k + 50);
      sw_a = 1'b1;
      push(k+51,  3, 2,       "a_hold_cnt_k51");
      push(k+51,  2, ST_HOLD, "a_hold_state_k51");
      push(k+100, 0, 0,       "a_hold_rst_k100");
      push(k+150, 0, 0,       "a_hold_rst_k150");
      push(k+151, 0, 1,       "a_hold_rst_k151");
      push(k+159, 0, 3,       "a_hold_rst_k159");
      @(negedge clk);
      sw_a = 1'b0;
      wait_until(k + 162);

      // Board reset mid-REL, checked before the next clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_reset("async");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      t0 = cyc;
      sched_boot(t0);
      wait_until(t0 + 130);

      chk("c_rel_never_entered", rel_seen, 0);
      chk("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
